// File: rtl/realtank_soc_bus_pkg.sv
// rtl/realtank_soc_bus_pkg.sv - shared AHB transfer-type and response encodings
package realtank_soc_bus_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

endpackage

// File: rtl/realtank_soc_bus_in_stage.sv
// rtl/realtank_soc_bus_in_stage.sv - AHB matrix input stage with transfer holding register
// Optional lock pass-through: define REALTANK_SOC_BUS_IN_STAGE_LOCK_EN.
module realtank_soc_bus_in_stage
    import realtank_soc_bus_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSELS,
    input  logic [AW-1:0] HADDRS,
    input  logic [1:0]    HTRANSS,
    input  logic          HWRITES,
    input  logic [2:0]    HSIZES,
    input  logic [2:0]    HBURSTS,
    input  logic [3:0]    HPROTS,
    input  logic          HMASTLOCKS,
    input  logic          HREADYS,
    output logic          HREADYOUTS,
    output logic [1:0]    HRESPS,
    output logic          sel_op,
    output logic [AW-1:0] addr_op,
    output logic [1:0]    trans_op,
    output logic          write_op,
    output logic [2:0]    size_op,
    output logic [2:0]    burst_op,
    output logic [3:0]    prot_op,
    output logic          master_lock_op,
    output logic          held_tran_op,
    input  logic          active_dec,
    input  logic          readyout_dec,
    input  logic [1:0]    resp_dec
);

    logic          w_trans_req;
    logic          w_load_reg;
    logic          w_accept;
    logic          r_pend_tran;
    logic          r_data_phase;
    logic [AW-1:0] r_addr;
    logic          r_write;
    logic [2:0]    r_size;
    logic [2:0]    r_burst;
    logic [3:0]    r_prot;

    assign w_trans_req = HSELS & HTRANSS[1];
    assign w_load_reg  = w_trans_req & HREADYS;
    assign w_accept    = (w_load_reg & active_dec) | (r_pend_tran & active_dec & readyout_dec);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
        end else if (w_load_reg) begin
            r_addr  <= HADDRS;
            r_write <= HWRITES;
            r_size  <= HSIZES;
            r_burst <= HBURSTS;
            r_prot  <= HPROTS;
        end
    end

    // A new unaccepted request wins over completion of the previous held one.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend_tran <= 1'b0;
        end else if (w_load_reg & ~active_dec) begin
            r_pend_tran <= 1'b1;
        end else if (active_dec & readyout_dec) begin
            r_pend_tran <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data_phase <= 1'b0;
        end else if (w_accept) begin
            r_data_phase <= 1'b1;
        end else if (HREADYS) begin
            r_data_phase <= 1'b0;
        end
    end

`ifdef REALTANK_SOC_BUS_IN_STAGE_LOCK_EN
    logic r_lock;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_lock <= 1'b0;
        end else if (w_load_reg) begin
            r_lock <= HMASTLOCKS;
        end
    end

    assign master_lock_op = r_pend_tran ? r_lock : HMASTLOCKS;
`else
    logic w_unused_lock;

    assign w_unused_lock  = HMASTLOCKS;
    assign master_lock_op = 1'b0;
`endif

    // A held transfer is re-issued as NONSEQ since arbitration may have broken the burst.
    assign sel_op       = r_pend_tran ? 1'b1          : HSELS;
    assign trans_op     = r_pend_tran ? HTRANS_NONSEQ : HTRANSS;
    assign addr_op      = r_pend_tran ? r_addr        : HADDRS;
    assign write_op     = r_pend_tran ? r_write       : HWRITES;
    assign size_op      = r_pend_tran ? r_size        : HSIZES;
    assign burst_op     = r_pend_tran ? r_burst       : HBURSTS;
    assign prot_op      = r_pend_tran ? r_prot        : HPROTS;
    assign held_tran_op = r_pend_tran;

    assign HREADYOUTS = r_pend_tran ? 1'b0 : (r_data_phase ? readyout_dec : 1'b1);
    assign HRESPS     = (r_data_phase & ~r_pend_tran) ? resp_dec : HRESP_OKAY;

endmodule

// File: tb/tb_realtank_soc_bus_in_stage.sv
// tb/tb_realtank_soc_bus_in_stage.sv - scoreboard bench for realtank_soc_bus_in_stage
module tb_realtank_soc_bus_in_stage;

    localparam int AW = 32;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSELS = 1'b0;
    logic [AW-1:0] HADDRS = '0;
    logic [1:0]    HTRANSS = 2'b00;
    logic          HWRITES = 1'b0;
    logic [2:0]    HSIZES = '0;
    logic [2:0]    HBURSTS = '0;
    logic [3:0]    HPROTS = '0;
    logic          HMASTLOCKS = 1'b0;
    logic          HREADYS;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;
    logic          sel_op;
    logic [AW-1:0] addr_op;
    logic [1:0]    trans_op;
    logic          write_op;
    logic [2:0]    size_op;
    logic [2:0]    burst_op;
    logic [3:0]    prot_op;
    logic          master_lock_op;
    logic          held_tran_op;
    logic          active_dec = 1'b0;
    logic          readyout_dec = 1'b1;
    logic [1:0]    resp_dec = 2'b00;

    // Single-slave system: the master sees this stage's own ready.
    assign HREADYS = HREADYOUTS;

    always #5 HCLK = ~HCLK;

    realtank_soc_bus_in_stage #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
        .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
        .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op), .write_op(write_op),
        .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
        .master_lock_op(master_lock_op), .held_tran_op(held_tran_op),
        .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec)
    );

    typedef struct {
        bit        sel;
        bit [31:0] addr;
        bit [1:0]  trans;
        bit        write;
        bit [2:0]  size;
        bit [2:0]  burst;
        bit [3:0]  prot;
        bit        lock;
        bit        active;
        bit        rdy;
        bit [1:0]  resp;
        bit        rstn;
    } stim_t;

    typedef struct {
        int        cyc;
        bit        sel;
        bit [31:0] addr;
        bit [1:0]  trans;
        bit        write;
        bit [2:0]  size;
        bit [2:0]  burst;
        bit [3:0]  prot;
        bit        lock;
        bit        held;
        bit        hready;
        bit [1:0]  hresp;
    } exp_t;

    exp_t  exp_q[$];
    stim_t held_q[$];
    bit    in_dp = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;

    function automatic stim_t mk(bit sel, bit [31:0] addr, bit [1:0] trans, bit write,
                                 bit active, bit rdy, bit [1:0] resp, bit lock, bit rstn);
        stim_t s;
        s.sel = sel; s.addr = addr; s.trans = trans; s.write = write;
        s.size = 3'b010; s.burst = 3'b001; s.prot = 4'b0011; s.lock = lock;
        s.active = active; s.rdy = rdy; s.resp = resp; s.rstn = rstn;
        return s;
    endfunction

    // Reference: at most one transfer is parked; the master only advances when the bus is ready.
    task automatic drive(input stim_t s);
        exp_t  e;
        stim_t d;
        bit    newreq;
        bit    accepted;
        @(posedge HCLK);
        #1;
        cyc++;
        HSELS = s.sel; HADDRS = s.addr; HTRANSS = s.trans; HWRITES = s.write;
        HSIZES = s.size; HBURSTS = s.burst; HPROTS = s.prot; HMASTLOCKS = s.lock;
        active_dec = s.active; readyout_dec = s.rdy; resp_dec = s.resp;
        HRESETn = s.rstn;
        if (!s.rstn) begin
            held_q.delete();
            in_dp = 1'b0;
        end
        e.cyc = cyc;
        if (held_q.size() != 0) begin
            d = held_q[0];
            e.sel = 1'b1; e.trans = 2'b10; e.addr = d.addr; e.write = d.write;
            e.size = d.size; e.burst = d.burst; e.prot = d.prot;
            e.held = 1'b1; e.hready = 1'b0; e.hresp = 2'b00;
`ifdef REALTANK_SOC_BUS_IN_STAGE_LOCK_EN
            e.lock = d.lock;
`else
            e.lock = 1'b0;
`endif
        end else begin
            e.sel = s.sel; e.trans = s.trans; e.addr = s.addr; e.write = s.write;
            e.size = s.size; e.burst = s.burst; e.prot = s.prot; e.held = 1'b0;
            e.hready = in_dp ? s.rdy : 1'b1;
            e.hresp  = in_dp ? s.resp : 2'b00;
`ifdef REALTANK_SOC_BUS_IN_STAGE_LOCK_EN
            e.lock = s.lock;
`else
            e.lock = 1'b0;
`endif
        end
        exp_q.push_back(e);
        if (s.rstn) begin
            newreq   = s.sel && (s.trans == 2'b10 || s.trans == 2'b11) && e.hready;
            accepted = (newreq && s.active) || (held_q.size() != 0 && s.active && s.rdy);
            if (newreq && !s.active) begin
                held_q.delete();
                held_q.push_back(s);
            end else if (held_q.size() != 0 && s.active && s.rdy) begin
                held_q.delete();
            end
            if (accepted) in_dp = 1'b1;
            else if (e.hready) in_dp = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sel_op",         e.cyc, 64'(sel_op),         64'(e.sel));
                chk("addr_op",        e.cyc, 64'(addr_op),        64'(e.addr));
                chk("trans_op",       e.cyc, 64'(trans_op),       64'(e.trans));
                chk("write_op",       e.cyc, 64'(write_op),       64'(e.write));
                chk("size_op",        e.cyc, 64'(size_op),        64'(e.size));
                chk("burst_op",       e.cyc, 64'(burst_op),       64'(e.burst));
                chk("prot_op",        e.cyc, 64'(prot_op),        64'(e.prot));
                chk("master_lock_op", e.cyc, 64'(master_lock_op), 64'(e.lock));
                chk("held_tran_op",   e.cyc, 64'(held_tran_op),   64'(e.held));
                chk("HREADYOUTS",     e.cyc, 64'(HREADYOUTS),     64'(e.hready));
                chk("HRESPS",         e.cyc, 64'(HRESPS),         64'(e.hresp));
            end
        end
    end

    initial begin
        stim_t s;
        // reset state
        repeat (2) drive(mk(1, 32'h0000_0abc, 2'b10, 0, 0, 1, 2'b00, 0, 0));
        drive(mk(0, 0, 2'b00, 0, 0, 1, 2'b00, 0, 1));
        // accepted NONSEQ write, then data phase wait then completion
        drive(mk(1, 32'h0000_1000, 2'b10, 1, 1, 1, 2'b00, 0, 1));
        drive(mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1));
        drive(mk(0, 0, 2'b00, 0, 0, 1, 2'b00, 0, 1));
        // held NONSEQ for three cycles, master changes address meanwhile
        drive(mk(1, 32'h0000_2000, 2'b10, 0, 0, 1, 2'b00, 0, 1));
        repeat (3) drive(mk(1, 32'h0000_9990, 2'b11, 1, 0, 1, 2'b00, 0, 1));
        drive(mk(1, 32'h0000_9990, 2'b11, 1, 1, 1, 2'b00, 0, 1));
        drive(mk(0, 0, 2'b00, 0, 0, 1, 2'b00, 0, 1));
        // held SEQ beat then an unchanged SEQ after release
        drive(mk(1, 32'h0000_2004, 2'b11, 0, 0, 1, 2'b00, 0, 1));
        drive(mk(1, 32'h0000_2004, 2'b11, 0, 1, 1, 2'b00, 0, 1));
        drive(mk(1, 32'h0000_2008, 2'b11, 0, 1, 1, 2'b00, 0, 1));
        drive(mk(0, 0, 2'b00, 0, 0, 1, 2'b00, 0, 1));
        // two-cycle ERROR with IDLE in the second cycle
        drive(mk(1, 32'h0000_3000, 2'b10, 0, 1, 1, 2'b00, 0, 1));
        drive(mk(1, 32'h0000_3004, 2'b10, 0, 1, 0, 2'b01, 0, 1));
        drive(mk(0, 32'h0000_3004, 2'b00, 0, 1, 1, 2'b01, 0, 1));
        drive(mk(0, 0, 2'b00, 0, 1, 1, 2'b00, 0, 1));
        // reset while a transfer is held, no replay afterwards
        drive(mk(1, 32'h0000_4000, 2'b10, 1, 0, 1, 2'b00, 0, 1));
        drive(mk(1, 32'h0000_4000, 2'b10, 1, 0, 1, 2'b00, 0, 1));
        drive(mk(0, 0, 2'b00, 0, 1, 1, 2'b00, 0, 0));
        repeat (3) drive(mk(0, 0, 2'b00, 0, 1, 1, 2'b00, 0, 1));
        // locked held transfer
        drive(mk(1, 32'h0000_5000, 2'b10, 1, 0, 1, 2'b00, 1, 1));
        drive(mk(1, 32'h0000_5000, 2'b10, 1, 0, 1, 2'b00, 0, 1));
        drive(mk(1, 32'h0000_5000, 2'b10, 1, 1, 1, 2'b00, 0, 1));
        drive(mk(0, 0, 2'b00, 0, 0, 1, 2'b00, 0, 1));
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            s.sel    = ($urandom_range(0, 9) < 8);
            s.addr   = $urandom;
            s.trans  = 2'($urandom_range(0, 3));
            s.write  = 1'($urandom);
            s.size   = 3'($urandom);
            s.burst  = 3'($urandom);
            s.prot   = 4'($urandom);
            s.lock   = 1'($urandom);
            s.active = 1'($urandom);
            s.rdy    = ($urandom_range(0, 9) < 7);
            s.resp   = 2'($urandom_range(0, 1));
            s.rstn   = ($urandom_range(0, 199) != 0);
            drive(s);
        end
        repeat (3) @(negedge HCLK);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
